// File: rtl/system_pio_pkg.sv
// Shared definitions for the parallel I/O slave: register offsets and edge modes.
package system_pio_pkg;

    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_DIR     = 3'd1;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_OUTCLR  = 3'd5;
    localparam logic [2:0] PIO_OUTTGL  = 3'd6;
    localparam logic [2:0] PIO_RSVD    = 3'd7;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/system_pio_gen_if.sv
// Avalon-MM slave bus bundle for the parallel I/O block.
interface system_pio_gen_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/system_pio_edge.sv
// Input conditioning: 2-flop synchroniser, history flop and edge decode.
module system_pio_edge
    import system_pio_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] raw_edge;
    // The pipe holds reset zeros for three cycles; edges are ignored until
    // sync2 and prev both hold real pin samples, so a pin already high at
    // reset is not mistaken for a transition.
    logic [2:0]       fill;

    // Shift the pins through the synchroniser and history stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            fill  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[1:0], 1'b1};
        end
    end

    assign in_sync = sync2;

    // Decode the selected edge type from current and previous samples.
    always_comb begin
        raw_edge = '0;
        case (EDGE_TYPE)
            EDGE_FALL: raw_edge = ~sync2 & prev;
            EDGE_ANY:  raw_edge = sync2 ^ prev;
            default:   raw_edge = sync2 & ~prev;
        endcase
        edge_pulse = fill[2] ? raw_edge : '0;
    end

endmodule

// File: rtl/system_pio_gen.sv
// Avalon-MM parallel I/O slave: data/direction registers, atomic set/clear/toggle,
// synchronised inputs with sticky edge capture and a masked level interrupt.
module system_pio_gen
    import system_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    system_pio_gen_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_nxt;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wd;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign rd_en = bus.chipselect & ~bus.read_n;
    assign wd    = bus.writedata[WIDTH-1:0];

    assign out_port = data_out;
    assign oe_port  = dir;

    system_pio_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    // Edge capture: a new edge outranks a same-cycle write-1-to-clear.
    always_comb begin
        w1c = '0;
        if (wr_en && (bus.address == PIO_EDGECAP))
            w1c = wd;
        edgecap_nxt = (edgecap & ~w1c) | edge_pulse;
    end

    // Register file writes, edge capture and interrupt flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
            dir      <= DIR_RESET[WIDTH-1:0];
            irqmask  <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            edgecap <= edgecap_nxt;
            irq     <= |(edgecap & irqmask);
            if (wr_en) begin
                case (bus.address)
                    PIO_DATA:    data_out <= wd;
                    PIO_DIR:     dir      <= wd;
                    PIO_IRQMASK: irqmask  <= wd;
                    PIO_OUTSET:  data_out <= data_out | wd;
                    PIO_OUTCLR:  data_out <= data_out & ~wd;
                    PIO_OUTTGL:  data_out <= data_out ^ wd;
                    default:     ;
                endcase
            end
        end
    end

    // Read mux from pre-write register state; write-only offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            PIO_DATA:    rd_mux = zext((dir & data_out) | (~dir & in_sync));
            PIO_DIR:     rd_mux = zext(dir);
            PIO_IRQMASK: rd_mux = zext(irqmask);
            PIO_EDGECAP: rd_mux = zext(edgecap);
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, held until the next accepted read.
    always_ff @(posedge clk) begin
        if (reset)
            bus.readdata <= '0;
        else if (rd_en)
            bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_system_pio_gen.sv
// Directed bench for system_pio_gen: a 32-bit rising-edge instance and an
// 8-bit falling-edge instance on a shared clock and reset.
module tb_system_pio_gen;
    import system_pio_pkg::*;

    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_RW = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in0 = 32'h0;
    logic [31:0] out0, oe0;
    logic        irq0;
    logic [7:0]  in8 = 8'h80;
    logic [7:0]  out8, oe8;
    logic        irq8;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[20];
    logic [31:0] rdv;

    system_pio_gen_if b0 ();
    system_pio_gen_if b1 ();

    system_pio_gen #(
        .WIDTH(32), .RESET_VALUE(32'h0000_5A5A), .DIR_RESET(32'hFFFF_0000), .EDGE_TYPE(EDGE_RISE)
    ) dut (
        .clk(clk), .reset(reset), .bus(b0.slave),
        .in_port(in0), .out_port(out0), .oe_port(oe0), .irq(irq0)
    );

    system_pio_gen #(
        .WIDTH(8), .RESET_VALUE(32'h0000_003C), .DIR_RESET(32'h0000_00FF), .EDGE_TYPE(EDGE_FALL)
    ) dut8 (
        .clk(clk), .reset(reset), .bus(b1.slave),
        .in_port(in8), .out_port(out8), .oe_port(oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic cs, input logic wn, input logic rn,
                         input logic [2:0] addr, input logic [31:0] wdata);
        if (!sel) begin
            b0.chipselect = cs; b0.write_n = wn; b0.read_n = rn;
            b0.address = addr; b0.writedata = wdata;
        end else begin
            b1.chipselect = cs; b1.write_n = wn; b1.read_n = rn;
            b1.address = addr; b1.writedata = wdata;
        end
    endtask

    task automatic idle(input bit sel);
        drive(sel, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic wr(input bit sel, input logic [2:0] addr, input logic [31:0] wdata);
        drive(sel, 1'b1, 1'b0, 1'b1, addr, wdata);
        cyc();
        idle(sel);
    endtask

    task automatic rd(input bit sel, input logic [2:0] addr, output logic [31:0] data);
        drive(sel, 1'b1, 1'b1, 1'b0, addr, 32'h0);
        cyc();
        idle(sel);
        data = sel ? b1.readdata : b0.readdata;
    endtask

    initial begin
        vecs[0]  = '{OP_WR, PIO_DATA,    32'h0000_000F, 32'h0,          32'h0000_000F};
        vecs[1]  = '{OP_WR, PIO_OUTSET,  32'h0000_00F0, 32'h0,          32'h0000_00FF};
        vecs[2]  = '{OP_WR, PIO_OUTCLR,  32'h0000_0003, 32'h0,          32'h0000_00FC};
        vecs[3]  = '{OP_WR, PIO_OUTTGL,  32'h0000_0081, 32'h0,          32'h0000_007D};
        vecs[4]  = '{OP_RD, PIO_OUTSET,  32'h0,         32'h0,          32'h0000_007D};
        vecs[5]  = '{OP_RD, PIO_DIR,     32'h0,         32'hFFFF_0000, 32'h0000_007D};
        vecs[6]  = '{OP_WR, PIO_DIR,     32'h0000_FFFF, 32'h0,          32'h0000_007D};
        vecs[7]  = '{OP_WR, PIO_DATA,    32'h0000_1234, 32'h0,          32'h0000_1234};
        vecs[8]  = '{OP_RD, PIO_DATA,    32'h0,         32'hABCD_1234, 32'h0000_1234};
        vecs[9]  = '{OP_RD, PIO_EDGECAP, 32'h0,         32'hABCD_0000, 32'h0000_1234};
        vecs[10] = '{OP_WR, PIO_EDGECAP, 32'hFFFF_FFFF, 32'h0,          32'h0000_1234};
        vecs[11] = '{OP_RD, PIO_EDGECAP, 32'h0,         32'h0,          32'h0000_1234};
        vecs[12] = '{OP_WR, PIO_IRQMASK, 32'h0000_0005, 32'h0,          32'h0000_1234};
        vecs[13] = '{OP_RD, PIO_IRQMASK, 32'h0,         32'h0000_0005, 32'h0000_1234};
        vecs[14] = '{OP_RD, PIO_RSVD,    32'h0,         32'h0,          32'h0000_1234};
        vecs[15] = '{OP_RD, PIO_OUTTGL,  32'h0,         32'h0,          32'h0000_1234};
        vecs[16] = '{OP_RW, PIO_DIR,     32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_1234};
        vecs[17] = '{OP_RD, PIO_DIR,     32'h0,         32'hFFFF_FFFF, 32'h0000_1234};
        vecs[18] = '{OP_RD, PIO_DATA,    32'h0,         32'h0000_1234, 32'h0000_1234};
        vecs[19] = '{OP_RD, PIO_OUTCLR,  32'h0,         32'h0,          32'h0000_1234};

        idle(1'b0);
        idle(1'b1);

        // reset held for two cycles
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_out", out0, 32'h0000_5A5A);
        chk("rst_oe", oe0, 32'hFFFF_0000);
        chk("rst_irq", {31'b0, irq0}, 32'h0);
        chk("rst_rdata", b0.readdata, 32'h0);
        chk("rst_out8", {24'b0, out8}, 32'h0000_003C);
        chk("rst_oe8", {24'b0, oe8}, 32'h0000_00FF);

        // let the input pipe fill with real samples, then raise upper pins
        repeat (4) cyc();
        in0 = 32'hABCD_0000;
        repeat (5) cyc();

        // table-driven register sequence on the 32-bit instance
        for (int i = 0; i < 20; i++) begin
            case (vecs[i].op)
                OP_WR: drive(1'b0, 1'b1, 1'b0, 1'b1, vecs[i].addr, vecs[i].wdata);
                OP_RD: drive(1'b0, 1'b1, 1'b1, 1'b0, vecs[i].addr, 32'h0);
                default: drive(1'b0, 1'b1, 1'b0, 1'b0, vecs[i].addr, vecs[i].wdata);
            endcase
            cyc();
            idle(1'b0);
            if (vecs[i].op != OP_WR)
                chk($sformatf("vec%0d_rd", i), b0.readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_out", i), out0, vecs[i].exp_out);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq0}, 32'h0);
        end

        // edge capture latency and irq timing on bit 0
        wr(1'b0, PIO_IRQMASK, 32'h1);
        in0 = in0 | 32'h1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, PIO_EDGECAP, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("edge_ec_k%0d", k), b0.readdata, (k >= 4) ? 32'h1 : 32'h0);
            chk($sformatf("edge_irq_k%0d", k), {31'b0, irq0}, (k >= 4) ? 32'h1 : 32'h0);
        end
        idle(1'b0);
        wr(1'b0, PIO_EDGECAP, 32'h1);
        chk("w1c_irq_still", {31'b0, irq0}, 32'h1);
        cyc();
        chk("w1c_irq_low", {31'b0, irq0}, 32'h0);

        // W1C of bit 2 lands on the same edge its rising edge is captured
        in0 = in0 | 32'h4;
        cyc();
        cyc();
        wr(1'b0, PIO_EDGECAP, 32'h4);
        rd(1'b0, PIO_EDGECAP, rdv);
        chk("collide_ec", rdv, 32'h4);
        chk("collide_irq", {31'b0, irq0}, 32'h0);
        wr(1'b0, PIO_EDGECAP, 32'h4);
        rd(1'b0, PIO_EDGECAP, rdv);
        chk("collide_clr", rdv, 32'h0);

        // 8-bit instance: width clipping, reserved read, falling edges
        rd(1'b1, PIO_EDGECAP, rdv);
        chk("w8_no_edge_high_at_reset", rdv, 32'h0);
        wr(1'b1, PIO_DATA, 32'hFFFF_FFFF);
        chk("w8_out", {24'b0, out8}, 32'h0000_00FF);
        rd(1'b1, PIO_DATA, rdv);
        chk("w8_data", rdv, 32'h0000_00FF);
        rd(1'b1, PIO_RSVD, rdv);
        chk("w8_rsvd", rdv, 32'h0);
        in8 = 8'h00;
        repeat (4) cyc();
        rd(1'b1, PIO_EDGECAP, rdv);
        chk("w8_fall_ec", rdv, 32'h0000_0080);
        wr(1'b1, PIO_DIR, 32'hFFFF_FF0F);
        rd(1'b1, PIO_DIR, rdv);
        chk("w8_dir", rdv, 32'h0000_000F);
        rd(1'b1, PIO_DATA, rdv);
        chk("w8_mixed", rdv, 32'h0000_000F);

        // reset during a combined read/write cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, PIO_DATA, 32'h0000_DEAD);
        reset = 1'b1;
        cyc();
        idle(1'b0);
        reset = 1'b0;
        chk("midrst_rdata", b0.readdata, 32'h0);
        chk("midrst_out", out0, 32'h0000_5A5A);
        chk("midrst_oe", oe0, 32'hFFFF_0000);
        chk("midrst_irq", {31'b0, irq0}, 32'h0);
        rd(1'b0, PIO_IRQMASK, rdv);
        chk("midrst_mask", rdv, 32'h0);
        repeat (3) cyc();
        rd(1'b0, PIO_DATA, rdv);
        chk("midrst_data", rdv, 32'h0000_0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
